// File: rtl/mod_seq_pkg.sv
// Shared types and default widths for the phase sequencer.
// Optional build macro: SEQ_RAMP_EN (tuning-word ramping at each wrap).
package mod_seq_pkg;

    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DIV_W_DEF  = 16;
    localparam logic [31:0] RAMP_STEP_DEF = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } seq_state_e;

    typedef logic [ACC_W_DEF-1:0] ftw_t;

endpackage

// File: rtl/mod_phase_sequencer_if.sv
// Valid/ready port carrying frequency-tuning words into the sequencer.
interface mod_phase_sequencer_if
    import mod_seq_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw;

    modport master (output cfg_valid, output cfg_ftw, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ftw, output cfg_ready);
endinterface

// File: rtl/mod_tick_prescaler.sv
// Sample-rate prescaler: tick_c every div+1 enabled clocks, restartable via clr.
module mod_tick_prescaler
    import mod_seq_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);
    logic [DIV_W-1:0] presc;

    assign tick_c = (presc == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick_c ? '0 : presc + DIV_W'(1);
        end
    end
endmodule

// File: rtl/mod_phase_sequencer.sv
// Phase-accumulator sequencer driving the waveform ROM address; new tuning
// words take effect only at the phase wrap. Build macro SEQ_RAMP_EN enables ramping.
module mod_phase_sequencer
    import mod_seq_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
`ifdef SEQ_RAMP_EN
    , parameter logic [31:0] RAMP_STEP = RAMP_STEP_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DIV_W-1:0]      div,
    mod_phase_sequencer_if.slave  cfg,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_en,
    output logic                  wrap,
    output logic                  running
);
    seq_state_e       state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [ACC_W-1:0] ftw_active, active_d;
    logic [ACC_W-1:0] sum_c;
    logic             carry_c, tick_c, clr_c, step_c, at_wrap_c, xfer_c;
    logic             wrap_d, ready_q, ready_d, running_d;

`ifdef SEQ_RAMP_EN
    localparam logic [ACC_W-1:0] RAMP_LIM = ACC_W'(RAMP_STEP);
    logic [ACC_W-1:0] ftw_tgt, tgt_d, ramp_delta, ftw_ramped;
    logic             ramp_up;
`else
    logic [ACC_W-1:0] ftw_pend, pend_word_d;
    logic             pend, pend_d;
`endif

    mod_tick_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state != IDLE),
        .clr    (clr_c),
        .div    (div),
        .tick_c (tick_c)
    );

    assign {carry_c, sum_c} = (ACC_W+1)'(acc) + (ACC_W+1)'(ftw_active);
    assign step_c    = tick_c && (state != IDLE);
    assign at_wrap_c = step_c && carry_c;
    assign xfer_c    = cfg.cfg_valid && ready_q;
    assign rom_addr  = acc[ACC_W-1 -: ADDR_W];
    assign cfg.cfg_ready = ready_q;

`ifdef SEQ_RAMP_EN
    // Bounded unsigned step of the active word toward the target.
    always_comb begin
        ramp_up    = (ftw_tgt > ftw_active);
        ramp_delta = ramp_up ? (ftw_tgt - ftw_active) : (ftw_active - ftw_tgt);
        if (ramp_delta > RAMP_LIM) ramp_delta = RAMP_LIM;
        ftw_ramped = ramp_up ? (ftw_active + ramp_delta) : (ftw_active - ramp_delta);
    end
`endif

    // Next-state, accumulator and tuning-word handoff.
    always_comb begin
        state_d  = state;
        acc_d    = acc;
        active_d = ftw_active;
        wrap_d   = 1'b0;
        clr_c    = 1'b0;
`ifdef SEQ_RAMP_EN
        tgt_d       = ftw_tgt;
`else
        pend_d      = pend;
        pend_word_d = ftw_pend;
`endif
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    clr_c   = 1'b1;
                end
            end
            RUN: begin
                if (stop) state_d = (ftw_active == '0) ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (start && !stop) state_d = RUN;
                else if ((stop && ftw_active == '0) || at_wrap_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (step_c) begin
            acc_d  = sum_c;
            wrap_d = carry_c;
        end
        // Leaving the active states always parks the phase at 0 degrees.
        if (state != IDLE && state_d == IDLE) acc_d = '0;

`ifdef SEQ_RAMP_EN
        if (state == IDLE) active_d = ftw_tgt;
        else if (at_wrap_c) active_d = ftw_ramped;
        if (xfer_c) tgt_d = cfg.cfg_ftw;
        ready_d = (active_d == tgt_d);
`else
        if (pend && (state == IDLE || at_wrap_c)) begin
            active_d = ftw_pend;
            pend_d   = 1'b0;
        end
        if (xfer_c) begin
            pend_word_d = cfg.cfg_ftw;
            pend_d      = 1'b1;
        end
        ready_d = !pend_d;
`endif
        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            ftw_active <= '0;
            wrap       <= 1'b0;
            ready_q    <= 1'b1;
            rom_en     <= 1'b0;
            running    <= 1'b0;
`ifdef SEQ_RAMP_EN
            ftw_tgt    <= '0;
`else
            ftw_pend   <= '0;
            pend       <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            ftw_active <= active_d;
            wrap       <= wrap_d;
            ready_q    <= ready_d;
            rom_en     <= running_d;
            running    <= running_d;
`ifdef SEQ_RAMP_EN
            ftw_tgt    <= tgt_d;
`else
            ftw_pend   <= pend_word_d;
            pend       <= pend_d;
`endif
        end
    end
endmodule

// File: tb/tb_mod_phase_sequencer.sv
// Bench for mod_phase_sequencer: directed scenarios plus random traffic
// compared every cycle against a behavioural phase model.
module tb_mod_phase_sequencer;
    import mod_seq_pkg::*;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DIV_W  = 16;
    localparam longint unsigned MOD = 64'h1_0000_0000;
`ifdef SEQ_RAMP_EN
    localparam logic [31:0] STEP = 32'h1000_0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en, wrap, running;

    mod_phase_sequencer_if #(.ACC_W(ACC_W)) cfg ();

    mod_phase_sequencer #(
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)
`ifdef SEQ_RAMP_EN
        , .RAMP_STEP(STEP)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .div      (div),
        .cfg      (cfg.slave),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .wrap     (wrap),
        .running  (running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: phase as plain modular arithmetic.
    bit              m_on, m_stop_req, m_wrap, m_ready, m_pend;
    longint unsigned m_phase, m_inc, m_cnt;
    ftw_t            m_pend_word, m_target;

    function automatic void model_reset();
        m_on = 0; m_stop_req = 0; m_wrap = 0; m_ready = 1; m_pend = 0;
        m_phase = 0; m_inc = 0; m_cnt = 0; m_pend_word = '0; m_target = '0;
    endfunction

    function automatic void model_edge();
        bit              accept, carry;
        longint unsigned inc_now, nxt, d;
        accept = cfg.cfg_valid && m_ready;
        carry  = 0;
        m_wrap = 0;
        if (!m_on) begin
`ifdef SEQ_RAMP_EN
            m_inc = m_target;
`else
            if (m_pend) begin m_inc = m_pend_word; m_pend = 0; end
`endif
            if (start && !stop) begin m_on = 1; m_stop_req = 0; m_cnt = 0; end
        end else begin
            inc_now = m_inc;
            if (m_cnt == longint'(div)) begin
                nxt = m_phase + inc_now;
                carry = (nxt >= MOD);
                m_phase = nxt % MOD;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_wrap = carry;
            if (stop && inc_now == 0) begin
                m_on = 0; m_phase = 0; m_stop_req = 0;
            end else if (!m_stop_req) begin
                m_stop_req = stop;
            end else if (start && !stop) begin
                m_stop_req = 0;
            end else if (carry) begin
                m_on = 0; m_phase = 0; m_stop_req = 0;
            end
            if (carry) begin
`ifdef SEQ_RAMP_EN
                if (longint'(m_target) > m_inc) begin
                    d = longint'(m_target) - m_inc;
                    m_inc += (d > longint'(STEP)) ? longint'(STEP) : d;
                end else begin
                    d = m_inc - longint'(m_target);
                    m_inc -= (d > longint'(STEP)) ? longint'(STEP) : d;
                end
`else
                if (m_pend) begin m_inc = m_pend_word; m_pend = 0; end
`endif
            end
        end
`ifdef SEQ_RAMP_EN
        if (accept) m_target = cfg.cfg_ftw;
        m_ready = (m_inc == longint'(m_target));
`else
        if (accept) begin m_pend_word = cfg.cfg_ftw; m_pend = 1; end
        m_ready = !m_pend;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("rom_addr", rom_addr, m_phase >> 16);
        check("rom_en", rom_en, m_on);
        check("running", running, m_on);
        check("wrap", wrap, m_wrap);
        check("cfg_ready", cfg.cfg_ready, m_ready);
    endtask

    task automatic offer(input logic [31:0] w);
        bit done = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ftw   = w;
        for (int i = 0; i < 64 && !done; i++) begin
            done = cfg.cfg_ready;
            cycle();
        end
        cfg.cfg_valid = 1'b0;
        check("offer_accepted", done, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && running; i++) cycle();
        check("wait_idle", running, 0);
    endtask

    task automatic count_wraps_to_ready(input string tag, input int exp_wraps);
        int w = 0;
        bit rdy = 0;
        for (int i = 0; i < 200 && !rdy; i++) begin
            cycle();
            if (wrap) w++;
            rdy = cfg.cfg_ready;
        end
        check(tag, w, exp_wraps);
    endtask

    logic [15:0] exp_addr [4];
    logic        exp_wrap [4];
    bit          rdy_s;

    initial begin
        exp_addr[0] = 16'h4000; exp_addr[1] = 16'h8000;
        exp_addr[2] = 16'hC000; exp_addr[3] = 16'h0000;
        exp_wrap[0] = 0; exp_wrap[1] = 0; exp_wrap[2] = 0; exp_wrap[3] = 1;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ftw   = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        check("rst_addr", rom_addr, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_wrap", wrap, 0);
        check("rst_running", running, 0);
        check("rst_ready", cfg.cfg_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // Quarter-turn tuning word, div=0.
        offer(32'h4000_0000);
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        check("t1_running", running, 1);
        check("t1_addr0", rom_addr, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t1_addr", rom_addr, exp_addr[i]);
            check("t1_wrap", wrap, exp_wrap[i]);
        end

        // Stop requested at 0x4000 completes the period.
        cycle();
        check("t4_at4000", rom_addr, 16'h4000);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("t4_addr8000", rom_addr, 16'h8000);
        check("t4_still_run", running, 1);
        cycle();
        check("t4_addrC000", rom_addr, 16'hC000);
        cycle();
        check("t4_idle_addr", rom_addr, 0);
        check("t4_idle_run", running, 0);
        check("t4_idle_en", rom_en, 0);
        check("t4_idle_wrap", wrap, 1);
        cycle();

        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check("idle_start_stop", running, 0);
        cycle();

        // Start while stopping cancels the stop.
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        check("t5_wrap", wrap, 1);
        check("t5_still_running", running, 1);
        cycle();
        check("t5_addr", rom_addr, 16'h4000);

`ifdef SEQ_RAMP_EN
        offer(32'h1000_0000);
        count_wraps_to_ready("ramp_down_wraps", 3);
        offer(32'h4000_0000);
        count_wraps_to_ready("ramp_up_wraps", 3);
`else
        // Mid-period retune waits for the wrap.
        offer(32'h2000_0000);
        check("t3_ready_low0", cfg.cfg_ready, 0);
        check("t3_addr8000", rom_addr, 16'h8000);
        cycle();
        check("t3_ready_low1", cfg.cfg_ready, 0);
        cycle();
        check("t3_wrap", wrap, 1);
        check("t3_addr0", rom_addr, 0);
        cycle();
        check("t3_addr2000", rom_addr, 16'h2000);
        check("t3_ready_high", cfg.cfg_ready, 1);
        cycle();
        check("t3_addr4000", rom_addr, 16'h4000);
`endif
        stop = 1'b1; cycle(); stop = 1'b0;
        wait_idle(200);

        // div=3: one ROM step per four clocks.
        div = 16'd3;
        offer(32'h0001_0000);
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("div3_addr", rom_addr, k / 4);
        end

        // Asynchronous reset with a word outstanding.
        offer(32'h0002_0000);
        check("pre_rst_ready", cfg.cfg_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", rom_addr, 0);
        check("arst_rom_en", rom_en, 0);
        check("arst_wrap", wrap, 0);
        check("arst_running", running, 0);
        check("arst_ready", cfg.cfg_ready, 1);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        div = '0;
        start = 1'b1; cycle(); start = 1'b0;
        check("zero_ftw_running", running, 1);
        repeat (3) cycle();
        check("pend_lost_addr", rom_addr, 0);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("zero_ftw_stop", running, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!m_on && $urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 2));
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if (!cfg.cfg_valid && $urandom_range(0, 9) == 0) begin
                cfg.cfg_valid = 1'b1;
                cfg.cfg_ftw   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
            end
            rdy_s = cfg.cfg_ready;
            cycle();
            if (cfg.cfg_valid && rdy_s) cfg.cfg_valid = 1'b0;
        end
        start = 1'b0; stop = 1'b0; cfg.cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mod_phase_sequencer.md
Name: mod_phase_sequencer

Overview:
Phase-accumulator controller that drives the 16-bit address of the three-phase waveform table.
- Provides start/stop sequencing, a programmable sample-rate prescaler and a valid/ready port for frequency-tuning words.
- Applies new tuning words glitch-free, only at the phase wrap (0°).
- Sits between the system/config logic and the waveform ROM; the ROM's three 120°-spaced outputs feed the PWM comparators.

Parameters:
- ACC_W, 32, phase accumulator width.
- ADDR_W, 16, ROM address width; rom_addr = acc[ACC_W-1 -: ADDR_W].
- DIV_W, 16, prescaler width.
- RAMP_STEP, 32'h0000_1000, max FTW change per wrap (SEQ_RAMP_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level/pulse: begin or resume output
- stop  in  1  request stop at next phase wrap
- div  in  DIV_W  tick every div+1 clocks; quasi-static
- cfg_valid  in  1  tuning word offered
- cfg_ready  out  1  sequencer can accept a tuning word
- cfg_ftw  in  ACC_W  frequency tuning word
- rom_addr  out  ADDR_W  ROM address (registered)
- rom_en  out  1  ROM enable; high while RUN/STOPPING
- wrap  out  1  one-cycle pulse on accumulator carry-out
- running  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, acc=0, presc=0, ftw_active=0, ftw_pend=0, pend=0. Outputs: rom_addr=0, rom_en=0, wrap=0, running=0, cfg_ready=1.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: start&&!stop -> RUN. start&&stop -> stay IDLE. stop alone is ignored.
  - RUN: stop -> STOPPING. stop has priority over start.
  - STOPPING: start&&!stop -> RUN (stop cancelled). On the wrap cycle -> IDLE, and acc is forced to 0 instead of the sum.
  - RUN or STOPPING with ftw_active==0 and stop -> IDLE next cycle, acc=0.
- Prescaler:
  - presc is cleared on entry to RUN from IDLE.
  - tick = (presc==div); presc wraps to 0 on tick.
  - div=0 gives a tick every clock.
- Accumulator: on tick in RUN/STOPPING, acc <= acc + ftw_active, mod 2^ACC_W.
  - wrap = registered carry-out of that add, high for exactly one cycle.
  - Outside ticks, acc holds.
- Latency: start sampled at edge N gives running=1 after N. With div=0, the first increment is at edge N+1, so rom_addr changes after N+1.
- Config handshake:
  - cfg_ready = !pend.
  - Transfer when cfg_valid&&cfg_ready: ftw_pend<=cfg_ftw, pend<=1.
  - In IDLE, pending is applied on the next edge: ftw_active<=ftw_pend, pend<=0.
  - In RUN/STOPPING, pending is applied on the same edge that produces the carry, so the next tick uses the new FTW. pend clears, and cfg_ready rises the cycle after wrap=1.
  - A transfer in the same cycle as a wrap is held until the following wrap.
  - cfg_valid while cfg_ready=0 is not accepted; the source must hold.
- Reset mid-operation: everything returns to reset values immediately; any pending FTW is discarded.

Optional Feature:
Macro SEQ_RAMP_EN.
- Defined:
  - Accepted words set ftw_target.
  - At each wrap, ftw_active moves toward ftw_target by min(|diff|, RAMP_STEP), unsigned.
  - cfg_ready=0 until ftw_active==ftw_target.
  - In IDLE, ftw_active jumps directly to target.
  - Stop-at-wrap semantics are unchanged.
- Undefined: step change at wrap as above; RAMP_STEP is unused.

Decomposition:
- Package mod_seq_pkg: state enum (IDLE/RUN/STOPPING), localparam defaults for ACC_W/ADDR_W/DIV_W, and the FTW type.
- One sub-module: mod_tick_prescaler (div counter, clear input, tick output).
- FSM, accumulator and handshake stay in the top.

Test Plan:
- div=0, ftw=0x4000_0000, start pulse -> rom_addr sequence 0x0000,0x4000,0x8000,0xC000,0x0000; wrap high only on the cycle rom_addr returns to 0x0000, once per 4 ticks.
- div=3, ftw=0x0001_0000 -> rom_addr increments by 1 every 4 clocks; wrap after 262144 clocks.
- Running with ftw=0x4000_0000, offer 0x2000_0000 mid-period -> cfg_ready low until wrap. Next period is 0x2000,0x4000,…; cfg_ready high the cycle after wrap.
- stop at rom_addr=0x4000 (ftw=0x4000_0000) -> addresses 0x8000,0xC000, then IDLE with rom_addr=0, rom_en=0, running=0. Also check start during STOPPING keeps RUN; start&&stop in IDLE stays IDLE.
- ftw_active=0, start then stop -> IDLE next cycle. rst_n low mid-RUN with pend=1 -> all outputs at reset values asynchronously; pending word lost.
- SEQ_RAMP_EN, RAMP_STEP=0x1000_0000, target 0x4000_0000 from 0x1000_0000 while running -> ftw_active 0x2000_0000, 0x3000_0000, 0x4000_0000 on successive wraps; cfg_ready high after the third.
